rv32_wb_data_master: RTL and testbench

- Wishbone B4 classic-cycle master for load/store accesses in the 0x2xxx_xxxx peripheral region.
- Sits beside the memory stage, on the same side as the on-chip data memory path.
- Latches the memory-stage access, runs one bus cycle and stalls the pipeline until the cycle completes.
- Returns the read word, registered, for the memory-stage read-data mux's Wishbone input.

---
 rtl/rv32_wb_data_master.sv | 176 +++++++++++++++++
 tb/tb_rv32_wb_data_master.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32_wb_data_master.sv
// rv32_wb_data_master
// Wishbone B4 classic-cycle master for memory-stage loads/stores that fall
// in the peripheral region (addr[31:28] == REGION). One access at a time:
// the access is latched, one bus cycle is run, and the pipeline is stalled
// until the cycle terminates. The read word is returned registered.
//
// Optional build macro: WB_TIMEOUT_EN -- forces an error termination after
// TIMEOUT_CYCLES bus cycles without ack/err. Without it, BUS waits forever.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no cycle in flight; launch on a region hit
// BUS   | cyc/stb asserted, waiting for ack/err (or timeout)
// DONE  | result valid, stall released; held while mem_hold_i is set so the
//       | same still-presented access is not launched a second time

module rv32_wb_data_master #(
  parameter logic [3:0] REGION         = 4'h2,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_be_i,
  input  logic        mem_hold_i,
  output logic        mem_stall_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero timeout would terminate before the slave could ever answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        hit;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign hit = mem_valid_i & (mem_addr_i[31:28] == REGION);

  // Next-state and register-update logic; every target defaults to hold.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef WB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (hit) begin
          adr_d   = mem_addr_i;
          we_d    = mem_write_i;
          dat_d   = mem_wdata_i;
          sel_d   = mem_write_i ? mem_be_i : 4'hF;
          cyc_d   = 1'b1;
          err_d   = 1'b0;
`ifdef WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = BUS;
        end
      end
      BUS: begin
        // err beats ack when both arrive together
        if (wb_err_i) begin
          cyc_d   = 1'b0;
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wb_ack_i) begin
          cyc_d   = 1'b0;
          if (!we_q) rdata_d = wb_dat_i;
          err_d   = 1'b0;
          state_d = DONE;
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // this is the TIMEOUT_CYCLES-th BUS cycle without termination
          cyc_d   = 1'b0;
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        if (!mem_hold_i) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bus/result registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      sel_q   <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Stall covers the launch cycle and all of BUS; released in DONE so the
  // M->W register samples the result.
  assign mem_stall_o = ~rst_i & (((state_q == IDLE) & hit) | (state_q == BUS));

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign mem_rdata_o = rdata_q;
  assign mem_err_o   = err_q;

endmodule

// File: tb/tb_rv32_wb_data_master.sv
// Directed bench for rv32_wb_data_master (default build, no timeout).
module tb_rv32_wb_data_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid_i, mem_write_i, mem_hold_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_be_i;
  logic        mem_stall_o, mem_err_o;
  logic [31:0] mem_rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  int total = 0;
  int bad   = 0;

  int stall_cnt  = 0;
  int stb_cnt    = 0;
  int launch_cnt = 0;
  logic stb_prev = 1'b0;

  rv32_wb_data_master dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mem_valid_i (mem_valid_i),
    .mem_write_i (mem_write_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_be_i    (mem_be_i),
    .mem_hold_i  (mem_hold_i),
    .mem_stall_o (mem_stall_o),
    .mem_rdata_o (mem_rdata_o),
    .mem_err_o   (mem_err_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Per-cycle activity counters, sampled with pre-edge values.
  always @(posedge clk_i) begin
    if (mem_stall_o) stall_cnt = stall_cnt + 1;
    if (wb_stb_o) stb_cnt = stb_cnt + 1;
    if (wb_stb_o && !stb_prev) launch_cnt = launch_cnt + 1;
    stb_prev = wb_stb_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access; ack/err presented after wait_n wait cycles. Returns in DONE.
  task automatic access(input string nm, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int wait_n, input logic ack, input logic err,
                        input logic [31:0] rdat);
    int s0_stall, s0_stb, n;
    logic [3:0] exp_sel;
    exp_sel = wr ? be : 4'hF;
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_write_i = wr; mem_addr_i = addr;
    mem_wdata_i = wdata; mem_be_i = be;
    s0_stall = stall_cnt; s0_stb = stb_cnt;
    #1 chk({nm, " stall_launch"}, 32'(mem_stall_o), 32'd1);
    @(negedge clk_i);
    n = 0;
    while (!wb_stb_o && n < 10) begin @(negedge clk_i); n++; end
    chk({nm, " stb_on_cycle1"}, n, 0);
    for (int i = 0; i <= wait_n; i++) begin
      chk({nm, " cyc"}, 32'(wb_cyc_o), 32'd1);
      chk({nm, " we"}, 32'(wb_we_o), 32'(wr));
      chk({nm, " adr"}, wb_adr_o, addr);
      chk({nm, " sel"}, 32'(wb_sel_o), 32'(exp_sel));
      if (wr) chk({nm, " dat"}, wb_dat_o, wdata);
      chk({nm, " stall_bus"}, 32'(mem_stall_o), 32'd1);
      if (i < wait_n) @(negedge clk_i);
    end
    wb_ack_i = ack; wb_err_i = err; wb_dat_i = rdat;
    @(negedge clk_i);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'hDEAD_BEEF;
    chk({nm, " stall_cycles"}, stall_cnt - s0_stall, wait_n + 2);
    chk({nm, " stb_cycles"}, stb_cnt - s0_stb, wait_n + 1);
    chk({nm, " done_cyc"}, 32'(wb_cyc_o), 32'd0);
    chk({nm, " done_stall"}, 32'(mem_stall_o), 32'd0);
  endtask

  initial begin
    int l0;
    logic [31:0] r_hold;
    rst_i = 1'b1; mem_valid_i = 1'b0; mem_write_i = 1'b0; mem_hold_i = 1'b0;
    mem_addr_i = 32'h0; mem_wdata_i = 32'h0; mem_be_i = 4'h0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst adr", wb_adr_o, 32'h0);
    chk("rst sel", 32'(wb_sel_o), 32'h0);
    chk("rst rdata", mem_rdata_o, 32'h0);
    chk("rst err", 32'(mem_err_o), 32'd0);
    mem_valid_i = 1'b1; mem_addr_i = 32'h2000_0000;
    #1 chk("rst stall_forced0", 32'(mem_stall_o), 32'd0);
    mem_valid_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b0;

    // load, ack at first stb cycle
    access("ld", 1'b0, 32'h2000_0004, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'hCAFE_F00D);
    chk("ld rdata", mem_rdata_o, 32'hCAFE_F00D);
    chk("ld err", 32'(mem_err_o), 32'd0);
    mem_valid_i = 1'b0;

    // store, 3 wait cycles; rdata untouched
    access("st", 1'b1, 32'h2000_0010, 32'h0000_1234, 4'b0011, 3, 1'b1, 1'b0, 32'h5555_AAAA);
    chk("st rdata_kept", mem_rdata_o, 32'hCAFE_F00D);
    chk("st err", 32'(mem_err_o), 32'd0);
    mem_valid_i = 1'b0;

    // data-memory region: no bus activity
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_write_i = 1'b0; mem_addr_i = 32'h1000_0000;
    l0 = launch_cnt;
    for (int i = 0; i < 3; i++) begin
      #1 chk("miss stall", 32'(mem_stall_o), 32'd0);
      chk("miss cyc", 32'(wb_cyc_o), 32'd0);
      @(negedge clk_i);
    end
    chk("miss launches", launch_cnt - l0, 0);
    mem_valid_i = 1'b0;

    // ack and err together: err wins
    access("er", 1'b0, 32'h2000_0020, 32'h0, 4'h0, 1, 1'b1, 1'b1, 32'h1111_2222);
    chk("er err", 32'(mem_err_o), 32'd1);
    chk("er rdata", mem_rdata_o, 32'h0);
    mem_valid_i = 1'b0;
    @(negedge clk_i);
    chk("er err_clears", 32'(mem_err_o), 32'd0);

    // hold in DONE with request still presented
    l0 = launch_cnt;
    access("hd", 1'b0, 32'h2000_0030, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h1234_5678);
    mem_hold_i = 1'b1;
    r_hold = mem_rdata_o;
    chk("hd rdata", r_hold, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("hd rdata_stable", mem_rdata_o, 32'h1234_5678);
      chk("hd err_stable", 32'(mem_err_o), 32'd0);
      chk("hd cyc", 32'(wb_cyc_o), 32'd0);
      chk("hd stall", 32'(mem_stall_o), 32'd0);
    end
    mem_hold_i = 1'b0; mem_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("hd one_launch", launch_cnt - l0, 1);

    // reset during BUS
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_write_i = 1'b1; mem_addr_i = 32'h2000_0040;
    mem_wdata_i = 32'hA5A5_5A5A; mem_be_i = 4'hC;
    @(negedge clk_i);
    chk("rb cyc_before", 32'(wb_cyc_o), 32'd1);
    rst_i = 1'b1; wb_ack_i = 1'b0;
    #1 chk("rb stall_in_rst", 32'(mem_stall_o), 32'd0);
    @(negedge clk_i);
    chk("rb cyc", 32'(wb_cyc_o), 32'd0);
    chk("rb stb", 32'(wb_stb_o), 32'd0);
    chk("rb we", 32'(wb_we_o), 32'd0);
    chk("rb adr", wb_adr_o, 32'h0);
    chk("rb dat", wb_dat_o, 32'h0);
    chk("rb sel", 32'(wb_sel_o), 32'h0);
    chk("rb rdata", mem_rdata_o, 32'h0);
    chk("rb err", 32'(mem_err_o), 32'd0);
    rst_i = 1'b0; mem_valid_i = 1'b0;
    #1 chk("rb idle_stall", 32'(mem_stall_o), 32'd0);
    @(negedge clk_i);
    chk("rb idle_cyc", 32'(wb_cyc_o), 32'd0);
    // IDLE must relaunch on a fresh hit
    mem_valid_i = 1'b1; mem_write_i = 1'b0; mem_addr_i = 32'h2000_0050;
    #1 chk("rb idle_hit_stall", 32'(mem_stall_o), 32'd1);
    @(negedge clk_i);
    chk("rb relaunch", 32'(wb_cyc_o), 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
    @(negedge clk_i);
    wb_ack_i = 1'b0; mem_valid_i = 1'b0;
    chk("rb relaunch_rdata", mem_rdata_o, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
